// File: rtl/fft_frame_buffer.sv
// Ping-pong frame buffer: windowed sample pairs fill one bank while the other streams to the FFT.
// First beat appears 2 cycles after a bank fills; out_ready stalls the stream; input pairs are dropped (overflow) when both banks are full.
module fft_frame_buffer #(
  parameter int DW = 12,
  parameter int N  = 2048,
  parameter int AW = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_first,
  input  logic [DW-1:0] in1,
  input  logic [DW-1:0] in2,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [AW-1:0] out_index,
  output logic          overflow,
  input  logic          ovf_clr
);

  localparam int PW = AW - 1;
  localparam logic [PW-1:0] PAIR_LAST = PW'(N / 2 - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(N - 1);

  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, next_state;

  // Even and odd samples live in separate RAMs so a whole pair is written per cycle.
  // Both RAMs are addressed by {bank, pair index}.
  logic [DW-1:0] mem_even [N];
  logic [DW-1:0] mem_odd  [N];

  logic [1:0]    bank_full, full_set, full_clr;
  logic          wr_bank, in_sync;
  logic [PW-1:0] wr_ptr, wr_pair;
  logic          wr_accept, wr_drop, wr_done;

  logic          rd_bank, iss_done, issue, rd_release;
  logic          ram_vld, out_load;
  logic [AW-1:0] rd_cnt, ram_idx;
  logic [DW-1:0] q_even, q_odd;

  // After reset nothing is written until a pair flagged in_first arrives.
  assign wr_pair   = in_first ? '0 : wr_ptr;
  assign wr_accept = in_valid & ~bank_full[wr_bank] & (in_first | in_sync);
  assign wr_drop   = in_valid & bank_full[wr_bank];
  assign wr_done   = wr_accept & (wr_pair == PAIR_LAST);

  assign full_set  = wr_done    ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr  = rd_release ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_even[{wr_bank, wr_pair}] <= in1;
      mem_odd[{wr_bank, wr_pair}]  <= in2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      wr_bank <= 1'b0;
      in_sync <= 1'b0;
    end else if (wr_accept) begin
      in_sync <= 1'b1;
      if (wr_done) begin
        wr_ptr  <= '0;
        wr_bank <= ~wr_bank;
      end else begin
        wr_ptr  <= wr_pair + 1'b1;
      end
    end
  end

  // Writer and reader always touch different banks, so set and clear never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= 2'b00;
    end else begin
      bank_full <= (bank_full | full_set) & ~full_clr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  assign out_load = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Index 0 is fetched in the same cycle the FSM leaves IDLE to shave a cycle off the start.
  always_comb begin
    next_state = state;
    issue      = 1'b0;
    rd_release = 1'b0;
    unique case (state)
      IDLE: begin
        if (bank_full[rd_bank]) begin
          next_state = STREAM;
          issue      = 1'b1;
        end
      end
      STREAM: begin
        issue = ~iss_done & (~ram_vld | out_load);
        if (out_valid && out_ready && out_last) begin
          rd_release = 1'b1;
          next_state = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_bank  <= 1'b0;
      rd_cnt   <= '0;
      iss_done <= 1'b0;
    end else begin
      if (issue) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (rd_cnt == IDX_LAST) begin
          iss_done <= 1'b1;
        end
      end
      if (rd_release) begin
        rd_bank  <= ~rd_bank;
        iss_done <= 1'b0;
      end
    end
  end

  // RAM output register only updates on a fetch, so it doubles as the skid slot during stalls.
  always_ff @(posedge clk) begin
    if (issue) begin
      q_even <= mem_even[{rd_bank, rd_cnt[AW-1:1]}];
      q_odd  <= mem_odd[{rd_bank, rd_cnt[AW-1:1]}];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_vld <= 1'b0;
      ram_idx <= '0;
    end else if (issue) begin
      ram_vld <= 1'b1;
      ram_idx <= rd_cnt;
    end else if (out_load) begin
      ram_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
    end else if (out_load) begin
      out_valid <= ram_vld;
      if (ram_vld) begin
        out_data  <= ram_idx[0] ? q_odd : q_even;
        out_index <= ram_idx;
        out_last  <= (ram_idx == IDX_LAST);
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_buffer.sv
// Directed bench for fft_frame_buffer: an N=8 instance for the scenarios, plus one N=2048 frame.
module tb_fft_frame_buffer;
  localparam int DW  = 12;
  localparam int N   = 8;
  localparam int AW  = 3;
  localparam int NB  = 2048;
  localparam int AWB = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_first = 1'b0, out_ready = 1'b0, ovf_clr = 1'b0;
  logic [DW-1:0] in1 = '0, in2 = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_last, overflow;
  logic [AW-1:0] out_index;

  logic           b_in_valid = 1'b0, b_in_first = 1'b0, b_ready = 1'b0, b_clr = 1'b0;
  logic [DW-1:0]  b_in1 = '0, b_in2 = '0;
  logic [DW-1:0]  b_data;
  logic           b_valid, b_last, b_ovf;
  logic [AWB-1:0] b_index;

  fft_frame_buffer #(.DW(DW), .N(N), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
    .in1(in1), .in2(in2), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .out_index(out_index),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  fft_frame_buffer #(.DW(DW), .N(NB), .AW(AWB)) dut_big (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_first(b_in_first),
    .in1(b_in1), .in2(b_in2), .out_data(b_data), .out_valid(b_valid),
    .out_ready(b_ready), .out_last(b_last), .out_index(b_index),
    .overflow(b_ovf), .ovf_clr(b_clr)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] cap_data [32];
  logic [AW-1:0] cap_idx  [32];
  logic          cap_last [32];
  int            cap_cyc  [32];
  int            cap_n;
  int            stall_err;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input bit first, input int a, input int b, input bit clr);
    in_valid = 1'b1;
    in_first = first;
    in1      = DW'(a);
    in2      = DW'(b);
    ovf_clr  = clr;
    tick();
    in_valid = 1'b0;
    in_first = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  task automatic send_frame(input int base);
    for (int k = 0; k < N / 2; k++) begin
      in_valid = 1'b1;
      in_first = (k == 0);
      in1      = DW'(base + 2 * k);
      in2      = DW'(base + 2 * k + 1);
      tick();
    end
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  // Records accepted beats and counts stalled beats whose outputs moved.
  task automatic capture(input int nb, input bit rnd);
    int            cyc;
    bit            stalled;
    logic [DW-1:0] hd;
    logic [AW-1:0] hi;
    logic          hl;
    cap_n = 0; stall_err = 0; cyc = 0; stalled = 0;
    hd = '0; hi = '0; hl = 1'b0;
    while (cap_n < nb && cyc < 400) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (stalled && (out_valid !== 1'b1 || out_data !== hd || out_index !== hi || out_last !== hl))
        stall_err++;
      stalled = (out_valid === 1'b1) && !out_ready;
      hd = out_data; hi = out_index; hl = out_last;
      if (out_valid === 1'b1 && out_ready) begin
        cap_data[cap_n] = out_data;
        cap_idx[cap_n]  = out_index;
        cap_last[cap_n] = out_last;
        cap_cyc[cap_n]  = cyc;
        cap_n++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset out_last: got %b want 0", out_last); end
    n_cmp++; if (out_data !== '0) begin n_err++; $display("FAIL reset out_data: got %0d want 0", out_data); end
    n_cmp++; if (out_index !== '0) begin n_err++; $display("FAIL reset out_index: got %0d want 0", out_index); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset overflow: got %b want 0", overflow); end
    n_cmp++; if (b_valid !== 1'b0) begin n_err++; $display("FAIL reset big out_valid: got %b want 0", b_valid); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    int lat;
    out_ready = 1'b0;
    send_frame(0);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 5) begin tick(); lat++; end
    n_cmp++; if (out_valid !== 1'b1 || lat > 3) begin n_err++; $display("FAIL single latency: got %0d cycles want <=3", lat); end
    capture(N, 1'b0);
    n_cmp++; if (cap_n !== N) begin n_err++; $display("FAIL single count: got %0d want %0d", cap_n, N); end
    for (int i = 0; i < cap_n; i++) begin
      n_cmp++;
      if (cap_data[i] !== DW'(i) || cap_idx[i] !== AW'(i) || cap_last[i] !== 1'(i == N - 1)) begin
        n_err++;
        $display("FAIL single beat %0d: data=%0d idx=%0d last=%b want data=%0d idx=%0d last=%b",
                 i, cap_data[i], cap_idx[i], cap_last[i], i, i, (i == N - 1));
      end
      n_cmp++;
      if (cap_cyc[i] !== cap_cyc[0] + i) begin
        n_err++; $display("FAIL single bubble beat %0d: cycle %0d want %0d", i, cap_cyc[i], cap_cyc[0] + i);
      end
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single tail out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_random_ready();
    out_ready = 1'b0;
    send_frame(0);
    capture(N, 1'b1);
    n_cmp++; if (cap_n !== N) begin n_err++; $display("FAIL random count: got %0d want %0d", cap_n, N); end
    for (int i = 0; i < cap_n; i++) begin
      n_cmp++;
      if (cap_data[i] !== DW'(i) || cap_idx[i] !== AW'(i) || cap_last[i] !== 1'(i == N - 1)) begin
        n_err++;
        $display("FAIL random beat %0d: data=%0d idx=%0d last=%b want data=%0d idx=%0d", i, cap_data[i], cap_idx[i], cap_last[i], i, i);
      end
    end
    n_cmp++; if (stall_err !== 0) begin n_err++; $display("FAIL random stall stability: got %0d changes want 0", stall_err); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL random tail out_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_overflow();
    int ed;
    out_ready = 1'b0;
    send_frame(100);
    send_frame(200);
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf premature: got %b want 0", overflow); end
    send_pair(1'b1, 999, 998, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf set: got %b want 1", overflow); end
    capture(2 * N, 1'b0);
    n_cmp++; if (cap_n !== 2 * N) begin n_err++; $display("FAIL ovf count: got %0d want %0d", cap_n, 2 * N); end
    for (int i = 0; i < cap_n; i++) begin
      ed = (i < N) ? 100 + i : 200 + i - N;
      n_cmp++;
      if (cap_data[i] !== DW'(ed) || cap_idx[i] !== AW'(i % N) || cap_last[i] !== 1'(i % N == N - 1)) begin
        n_err++;
        $display("FAIL ovf beat %0d: data=%0d idx=%0d last=%b want data=%0d idx=%0d", i, cap_data[i], cap_idx[i], cap_last[i], ed, i % N);
      end
    end
    repeat (4) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf dropped pair streamed: out_valid %b want 0", out_valid); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf clear: got %b want 0", overflow); end
  endtask

  task automatic test_restart();
    out_ready = 1'b0;
    send_pair(1'b1, 1, 2, 1'b0);
    send_pair(1'b0, 3, 4, 1'b0);
    send_frame(50);
    capture(N, 1'b0);
    n_cmp++; if (cap_n !== N) begin n_err++; $display("FAIL restart count: got %0d want %0d", cap_n, N); end
    for (int i = 0; i < cap_n; i++) begin
      n_cmp++;
      if (cap_data[i] !== DW'(50 + i) || cap_idx[i] !== AW'(i)) begin
        n_err++; $display("FAIL restart beat %0d: data=%0d idx=%0d want data=%0d idx=%0d", i, cap_data[i], cap_idx[i], 50 + i, i);
      end
    end
    repeat (4) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL restart partial streamed: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    int c;
    out_ready = 1'b0;
    send_frame(10);
    send_frame(20);
    send_pair(1'b1, 5, 5, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL rstmid ovf before: got %b want 1", overflow); end
    out_ready = 1'b1;
    c = 0;
    @(negedge clk);
    while (!(out_valid === 1'b1 && out_index === AW'(3)) && c < 20) begin @(negedge clk); c++; end
    n_cmp++; if (c >= 20) begin n_err++; $display("FAIL rstmid timeout waiting for index 3: waited %0d want <20", c); end
    n_cmp++; if (out_data !== DW'(13)) begin n_err++; $display("FAIL rstmid data at index 3: got %0d want 13", out_data); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid out_valid: got %b want 0", out_valid); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rstmid overflow: got %b want 0", overflow); end
    n_cmp++; if (out_index !== '0 || out_last !== 1'b0) begin n_err++; $display("FAIL rstmid index/last: got %0d/%b want 0/0", out_index, out_last); end
    out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (4) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid stale frame: out_valid %b want 0", out_valid); end
    send_frame(70);
    capture(N, 1'b0);
    n_cmp++; if (cap_n !== N) begin n_err++; $display("FAIL rstmid count: got %0d want %0d", cap_n, N); end
    for (int i = 0; i < cap_n; i++) begin
      n_cmp++;
      if (cap_data[i] !== DW'(70 + i) || cap_idx[i] !== AW'(i) || cap_last[i] !== 1'(i == N - 1)) begin
        n_err++; $display("FAIL rstmid beat %0d: data=%0d idx=%0d want data=%0d idx=%0d", i, cap_data[i], cap_idx[i], 70 + i, i);
      end
    end
  endtask

  task automatic test_ovf_clr();
    int ed;
    out_ready = 1'b0;
    send_frame(80);
    send_frame(90);
    send_pair(1'b1, 5, 5, 1'b1);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovfclr set wins: got %b want 1", overflow); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovfclr clear: got %b want 0", overflow); end
    capture(2 * N, 1'b0);
    n_cmp++; if (cap_n !== 2 * N) begin n_err++; $display("FAIL ovfclr count: got %0d want %0d", cap_n, 2 * N); end
    for (int i = 0; i < cap_n; i++) begin
      ed = (i < N) ? 80 + i : 90 + i - N;
      n_cmp++;
      if (cap_data[i] !== DW'(ed) || cap_idx[i] !== AW'(i % N)) begin
        n_err++; $display("FAIL ovfclr beat %0d: data=%0d idx=%0d want data=%0d idx=%0d", i, cap_data[i], cap_idx[i], ed, i % N);
      end
    end
  endtask

  task automatic test_big();
    int cnt, err, c, first_c, last_c;
    b_ready = 1'b1;
    for (int k = 0; k < NB / 2; k++) begin
      b_in_valid = 1'b1;
      b_in_first = (k == 0);
      b_in1      = DW'(2 * k);
      b_in2      = DW'(2 * k + 1);
      tick();
    end
    b_in_valid = 1'b0;
    b_in_first = 1'b0;
    cnt = 0; err = 0; c = 0; first_c = 0; last_c = 0;
    while (cnt < NB && c < 4000) begin
      @(negedge clk);
      if (b_valid === 1'b1 && b_ready) begin
        if (b_data !== DW'(cnt) || b_index !== AWB'(cnt) || b_last !== 1'(cnt == NB - 1)) err++;
        if (cnt == 0) first_c = c;
        last_c = c;
        cnt++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    n_cmp++; if (cnt !== NB) begin n_err++; $display("FAIL big count: got %0d want %0d", cnt, NB); end
    n_cmp++; if (err !== 0) begin n_err++; $display("FAIL big beats: got %0d wrong beats want 0", err); end
    n_cmp++; if (last_c - first_c !== NB - 1) begin n_err++; $display("FAIL big bubbles: span %0d want %0d", last_c - first_c, NB - 1); end
    n_cmp++; if (b_ovf !== 1'b0) begin n_err++; $display("FAIL big overflow: got %b want 0", b_ovf); end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_random_ready();
    test_overflow();
    test_restart();
    test_reset_mid();
    test_ovf_clr();
    test_big();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
